// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq
// Registered N-to-2^N one-hot line decoder with two modes:
//   direct - decodes addresses accepted over a valid/ready handshake
//   scan   - steps the select through 0..scan_last, holding each index DWELL cycles
// The select is built from the next-state index and registered, so it only
// ever changes on a clock edge and is never multi-hot.
// ACTIVE_LOW inverts only the sel bus. idx, sel_valid and wrap keep their sense.

module decoder_scan_seq #(
    parameter int N          = 3,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       addr,
    input  logic [N-1:0]       scan_last,
    output logic [(1<<N)-1:0]  sel,
    output logic [N-1:0]       idx,
    output logic               sel_valid,
    output logic               wrap
);

    localparam int W  = 1 << N;
    // The dwell counter needs at least one bit, even when DWELL is 1.
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [DW-1:0] DWELL_ZERO = DW'(0);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [N-1:0]  IDX_ZERO   = N'(0);
    localparam logic [N-1:0]  IDX_ONE    = N'(1);
    // Pattern of an inactive sel bus. XOR with this mask applies the output polarity.
    localparam logic [W-1:0]  POL_MASK   = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // Active-high one-hot code for index i.
    function automatic logic [W-1:0] onehot_f(input logic [N-1:0] i);
        logic [W-1:0] v;
        v = {W{1'b0}};
        v[i] = 1'b1;
        return v;
    endfunction

    // Output-polarity sel pattern for a given valid flag and index.
    function automatic logic [W-1:0] sel_code_f(input logic vld, input logic [N-1:0] i);
        logic [W-1:0] v;
        if (vld) begin
            v = onehot_f(i) ^ POL_MASK;
        end else begin
            v = POL_MASK;
        end
        return v;
    endfunction

    state_t          state_r,     state_n_s;
    logic [N-1:0]    idx_r,       idx_n_s;
    logic [N-1:0]    last_q_r,    last_n_s;
    logic [DW-1:0]   dwell_r,     dwell_n_s;
    logic            sel_valid_r, sel_valid_n_s;
    logic            wrap_r,      wrap_n_s;
    logic [W-1:0]    sel_r,       sel_n_s;
    logic            in_ready_s;
    logic            accept_s;

    // Handshake readiness: only in direct mode and never while the FSM is in SCAN.
    always_comb begin
        in_ready_s = en && !mode && (state_r != ST_SCAN);
        accept_s   = in_valid && in_ready_s;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n_s     = state_r;
        idx_n_s       = idx_r;
        last_n_s      = last_q_r;
        dwell_n_s     = dwell_r;
        sel_valid_n_s = sel_valid_r;
        wrap_n_s      = 1'b0;

        if (!en) begin
            // Disable overrides every state: select goes inactive, scan position lost.
            state_n_s     = ST_IDLE;
            idx_n_s       = IDX_ZERO;
            dwell_n_s     = DWELL_ZERO;
            sel_valid_n_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DIRECT: begin
                    if (mode) begin
                        // Scan entry; any address offered in this cycle is not accepted.
                        state_n_s     = ST_SCAN;
                        idx_n_s       = IDX_ZERO;
                        dwell_n_s     = DWELL_ZERO;
                        last_n_s      = scan_last;
                        sel_valid_n_s = 1'b1;
                    end else if (accept_s) begin
                        state_n_s     = ST_DIRECT;
                        idx_n_s       = addr;
                        sel_valid_n_s = 1'b1;
                    end else begin
                        state_n_s     = state_r;
                    end
                end
                ST_SCAN: begin
                    if (!mode) begin
                        // Leaving scan drops the select; re-entry restarts from 0.
                        state_n_s     = ST_IDLE;
                        idx_n_s       = IDX_ZERO;
                        dwell_n_s     = DWELL_ZERO;
                        sel_valid_n_s = 1'b0;
                    end else if (dwell_r == DWELL_LAST) begin
                        dwell_n_s = DWELL_ZERO;
                        if (idx_r == last_q_r) begin
                            // End of sweep: scan_last is only re-sampled here.
                            idx_n_s  = IDX_ZERO;
                            wrap_n_s = 1'b1;
                            last_n_s = scan_last;
                        end else begin
                            idx_n_s  = idx_r + IDX_ONE;
                        end
                    end else begin
                        dwell_n_s = dwell_r + DWELL_ONE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a safe inactive state.
                    state_n_s     = ST_IDLE;
                    idx_n_s       = IDX_ZERO;
                    dwell_n_s     = DWELL_ZERO;
                    sel_valid_n_s = 1'b0;
                end
            endcase
        end

        sel_n_s = sel_code_f(sel_valid_n_s, idx_n_s);
    end

    // State and output registers; reset clears every output asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= IDX_ZERO;
            last_q_r    <= IDX_ZERO;
            dwell_r     <= DWELL_ZERO;
            sel_valid_r <= 1'b0;
            wrap_r      <= 1'b0;
            sel_r       <= POL_MASK;
        end else begin
            state_r     <= state_n_s;
            idx_r       <= idx_n_s;
            last_q_r    <= last_n_s;
            dwell_r     <= dwell_n_s;
            sel_valid_r <= sel_valid_n_s;
            wrap_r      <= wrap_n_s;
            sel_r       <= sel_n_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign sel       = sel_r;
    assign idx       = idx_r;
    assign sel_valid = sel_valid_r;
    assign wrap      = wrap_r;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed bench for decoder_scan_seq (N=3, DWELL=2). A second instance with
// ACTIVE_LOW=1 shares all inputs and is expected to show the inverted sel.
`timescale 1ns/1ps

module tb_decoder_scan_seq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic       in_valid;
    logic [2:0] addr;
    logic [2:0] scan_last;

    logic       in_ready,  in_ready_al;
    logic [7:0] sel,       sel_al;
    logic [2:0] idx,       idx_al;
    logic       sel_valid, sel_valid_al;
    logic       wrap,      wrap_al;

    int tests;
    int fails;

    decoder_scan_seq #(.N(3), .DWELL(2), .ACTIVE_LOW(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .addr(addr),
        .scan_last(scan_last), .sel(sel), .idx(idx),
        .sel_valid(sel_valid), .wrap(wrap)
    );

    decoder_scan_seq #(.N(3), .DWELL(2), .ACTIVE_LOW(1)) u_dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_al), .addr(addr),
        .scan_last(scan_last), .sel(sel_al), .idx(idx_al),
        .sel_valid(sel_valid_al), .wrap(wrap_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full output check of both instances against an expected valid/index/wrap.
    task automatic chk_out(input string tag, input logic vld, input logic [2:0] i, input logic w);
        logic [7:0] exp_sel;
        exp_sel = vld ? (8'h01 << i) : 8'h00;
        chk({tag, ".sel"},       {24'h0, sel},    {24'h0, exp_sel});
        chk({tag, ".sel_al"},    {24'h0, sel_al}, {24'h0, ~exp_sel});
        chk({tag, ".sel_valid"}, {31'h0, sel_valid}, {31'h0, vld});
        chk({tag, ".idx"},       {29'h0, idx},    {29'h0, (vld ? i : 3'd0)});
        chk({tag, ".wrap"},      {31'h0, wrap},   {31'h0, w});
    endtask

    // Every cycle: sel never multi-hot, consistent with idx/sel_valid, and the
    // inverted instance mirrors it.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            tests++;
            assert (($countones(sel) <= 1) &&
                    (sel === (sel_valid ? (8'h01 << idx) : 8'h00)) &&
                    (sel_al === ~sel)) else begin
                fails++;
                $error("FAIL onehot_mon: observed sel=%0h sel_al=%0h idx=%0d vld=%0b expected one-hot of idx", sel, sel_al, idx, sel_valid);
            end
        end
    end

    initial begin
        int scan_idx [22];
        int scan_wrap [22];
        scan_idx  = '{0,0,1,1,2,2,3,3,0,0,1,1,2,2,3,3,0,0,1,1,0,0};
        scan_wrap = '{0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,1,0,0,0,1,0};
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b1;
        en        = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        addr      = 3'd0;
        scan_last = 3'd0;

        // Reset
        #1 rst_n = 1'b0;
        #1;
        chk_out("reset", 1'b0, 3'd0, 1'b0);
        #1 rst_n = 1'b1;
        chk("reset.in_ready", {31'h0, in_ready}, 32'd1);

        // Direct: back-to-back accepts 5, 0, 7
        in_valid = 1'b1; addr = 3'd5;
        tick();
        chk_out("direct5", 1'b1, 3'd5, 1'b0);
        addr = 3'd0;
        tick();
        chk_out("direct0", 1'b1, 3'd0, 1'b0);
        addr = 3'd7;
        tick();
        chk_out("direct7", 1'b1, 3'd7, 1'b0);
        in_valid = 1'b0; addr = 3'd1;
        tick();
        chk_out("hold7a", 1'b1, 3'd7, 1'b0);
        tick();
        chk_out("hold7b", 1'b1, 3'd7, 1'b0);
        chk("direct.in_ready", {31'h0, in_ready}, 32'd1);
        in_valid = 1'b1; addr = 3'd2;
        tick();
        chk_out("direct2", 1'b1, 3'd2, 1'b0);
        chk("al_direct2", {24'h0, sel_al}, 32'h0000_00FB);
        in_valid = 1'b0;

        // Scan with scan_last=3, changed to 1 mid-sweep at idx=1
        scan_last = 3'd3; mode = 1'b1;
        for (int k = 0; k < 22; k++) begin
            tick();
            chk_out($sformatf("scan%0d", k), 1'b1, 3'(scan_idx[k]), scan_wrap[k] != 0);
            chk($sformatf("scan%0d.in_ready", k), {31'h0, in_ready}, 32'd0);
            if (k == 10) scan_last = 3'd1;
        end

        // Leave scan, then scan with scan_last=0
        mode = 1'b0;
        tick();
        chk_out("scan_exit", 1'b0, 3'd0, 1'b0);
        chk("al_idle", {24'h0, sel_al}, 32'h0000_00FF);
        scan_last = 3'd0; mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_out($sformatf("last0_%0d", k), 1'b1, 3'd0, (k >= 2) && (k % 2 == 0));
        end

        // Drop en at idx=2, then re-enable
        mode = 1'b0;
        tick();
        scan_last = 3'd3; mode = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk_out("pre_drop", 1'b1, 3'd2, 1'b0);
        en = 1'b0;
        chk("dis.in_ready", {31'h0, in_ready}, 32'd0);
        tick();
        chk_out("en_drop", 1'b0, 3'd0, 1'b0);
        chk("al_disabled", {24'h0, sel_al}, 32'h0000_00FF);
        en = 1'b1;
        tick();
        chk_out("reen0", 1'b1, 3'd0, 1'b0);
        tick();
        chk_out("reen1", 1'b1, 3'd0, 1'b0);
        tick();
        chk_out("reen2", 1'b1, 3'd1, 1'b0);

        // Asynchronous reset mid-cycle, away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 3'd0, 1'b0);
        #1 rst_n = 1'b1;
        mode = 1'b0;
        #1;
        chk("post_rst.in_ready", {31'h0, in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
